// File: rtl/cpu_forward_scoreboard_pkg.sv
// Shared types for the decode-stage operand forwarding path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package CPU_Types;

  // Widest data / register index any forwarding instance may be built with.
  localparam int FWD_XLEN_MAX  = 64;
  localparam int FWD_REG_W_MAX = 8;

  // Architectural zero register: reads as zero, never forwarded, never stalls.
  localparam logic [FWD_REG_W_MAX-1:0] REG_ZERO = '0;

  // One downstream pipeline stage as seen by the forwarding search.
  // Narrower instances zero-extend their fields into this record.
  typedef struct packed {
    logic                     valid;
    logic [FWD_REG_W_MAX-1:0] rd_idx;
    logic [FWD_XLEN_MAX-1:0]  rd_data;
    logic                     rd_ready;
  } fwd_stage_t;

  // True when the stage writes the register the operand wants.
  function automatic logic fwd_hit(input fwd_stage_t stg,
                                   input logic [FWD_REG_W_MAX-1:0] idx);
    return stg.valid && (stg.rd_idx == idx);
  endfunction

endpackage

// File: rtl/cpu_forward_scoreboard_counter.sv
// Per-register outstanding long-latency write counter, saturating at both ends.
// Latency: count updates on the clock edge after inc/dec/flush.
// Backpressure: none; err_o flags an illegal inc at max or dec at zero (count holds).
module cpu_scoreboard_counter #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: flush wins, simultaneous inc/dec cancel, ends hold and flag.
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) err_o = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register; reset drops all outstanding writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_forward_scoreboard.sv
// Decode-stage operand forwarding and long-latency write scoreboard.
// Latency: operands/stall combinational (0 cycles); scoreboard visible 1 cycle after issue/retire edge.
// Backpressure: o_stall holds decode on unready forwards, pending writes, or a saturated counter.
module cpu_forward_scoreboard
  import CPU_Types::*;
#(
  parameter int NUM_RS      = 3,
  parameter int NUM_STAGES  = 3,
  parameter int XLEN        = 32,
  parameter int REG_W       = 5,
  parameter int MAX_PENDING = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_RS-1:0]                    i_rs_valid,
  input  logic [NUM_RS-1:0][REG_W-1:0]         i_rs_idx,
  input  logic [NUM_RS-1:0][XLEN-1:0]          i_rs_rf,
  input  logic [NUM_STAGES-1:0]                i_stage_valid,
  input  logic [NUM_STAGES-1:0][REG_W-1:0]     i_stage_rd_idx,
  input  logic [NUM_STAGES-1:0][XLEN-1:0]      i_stage_rd_data,
  input  logic [NUM_STAGES-1:0]                i_stage_rd_ready,
  input  logic                                 i_issue,
  input  logic                                 i_issue_long,
  input  logic [REG_W-1:0]                     i_issue_rd,
  input  logic                                 i_retire,
  input  logic [REG_W-1:0]                     i_retire_rd,
  input  logic                                 i_flush,
  output logic [NUM_RS-1:0][XLEN-1:0]          o_rs,
  output logic                                 o_stall,
  output logic [(2**REG_W)-1:0]                o_busy,
  output logic                                 o_error
);

  localparam int NUM_REGS = 2**REG_W;
  localparam int CNT_W    = $clog2(MAX_PENDING + 1);

  fwd_stage_t                 stage [NUM_STAGES];
  logic [NUM_STAGES-1:0]      stage_data_unused;
  logic [CNT_W-1:0]           pending [NUM_REGS];
  logic [NUM_REGS-1:0]        cnt_err;
  logic [NUM_RS-1:0]          hazard;
  logic                       sat_stall;
  logic                       error_q, error_d;

  // Widen each stage into the shared record; bits above XLEN are zero and sink unused.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign stage[s] = '{valid:    i_stage_valid[s],
                        rd_idx:   FWD_REG_W_MAX'(i_stage_rd_idx[s]),
                        rd_data:  FWD_XLEN_MAX'(i_stage_rd_data[s]),
                        rd_ready: i_stage_rd_ready[s]};
    assign stage_data_unused[s] = ^stage[s].rd_data;
  end

  // Register zero is hardwired: never pending, never in error.
  assign pending[0] = '0;
  assign cnt_err[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic inc, dec;
    assign inc = i_issue && i_issue_long && (i_issue_rd == REG_W'(r));
    assign dec = i_retire && (i_retire_rd == REG_W'(r));

    cpu_scoreboard_counter #(
      .MAX_PENDING (MAX_PENDING),
      .CNT_W       (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (i_flush),
      .inc_i   (inc),
      .dec_i   (dec),
      .cnt_o   (pending[r]),
      .err_o   (cnt_err[r])
    );
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
    assign o_busy[r] = (pending[r] != '0);
  end

  for (genvar n = 0; n < NUM_RS; n++) begin : g_rs
    logic [FWD_REG_W_MAX-1:0] idx_ext;
    logic [XLEN-1:0]          rs_res;
    logic                     rs_haz;
    logic                     found;

    assign idx_ext = FWD_REG_W_MAX'(i_rs_idx[n]);

    // Youngest matching stage wins; unready winner or pending long write is a hazard.
    always_comb begin
      rs_res = '0;
      rs_haz = 1'b0;
      found  = 1'b0;
      if (i_rs_valid[n] && (idx_ext != REG_ZERO)) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (!found && fwd_hit(stage[s], idx_ext)) begin
            found = 1'b1;
            if (stage[s].rd_ready) rs_res = stage[s].rd_data[XLEN-1:0];
            else                   rs_haz = 1'b1;
          end
        end
        if (!found) begin
          if (pending[i_rs_idx[n]] != '0) rs_haz = 1'b1;
          else                            rs_res = i_rs_rf[n];
        end
      end
    end

    assign o_rs[n]   = rs_res;
    assign hazard[n] = rs_haz;
  end

  // A long candidate whose destination counter is full must wait for a retire.
  assign sat_stall = i_issue_long && (pending[i_issue_rd] == CNT_W'(MAX_PENDING));
  assign o_stall   = (|hazard) || sat_stall;

  // Sticky protocol error: issuing through a stall or any counter over/underflow.
  always_comb begin
    error_d = error_q || (i_issue && o_stall) || (|cnt_err);
  end

  // Error flag register; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) error_q <= 1'b0;
    else         error_q <= error_d;
  end

  assign o_error = error_q;

endmodule

// File: tb/tb_cpu_forward_scoreboard.sv
module tb_cpu_forward_scoreboard;

  localparam int NUM_RS      = 3;
  localparam int NUM_STAGES  = 3;
  localparam int XLEN        = 32;
  localparam int REG_W       = 5;
  localparam int MAX_PENDING = 3;
  localparam int NUM_REGS    = 2**REG_W;

  localparam int K_RS = 0, K_STALL = 1, K_BUSY = 2, K_ERR = 3;

  logic                             clk_i = 1'b0;
  logic                             rst_ni;
  logic [NUM_RS-1:0]                i_rs_valid;
  logic [NUM_RS-1:0][REG_W-1:0]     i_rs_idx;
  logic [NUM_RS-1:0][XLEN-1:0]      i_rs_rf;
  logic [NUM_STAGES-1:0]            i_stage_valid;
  logic [NUM_STAGES-1:0][REG_W-1:0] i_stage_rd_idx;
  logic [NUM_STAGES-1:0][XLEN-1:0]  i_stage_rd_data;
  logic [NUM_STAGES-1:0]            i_stage_rd_ready;
  logic                             i_issue, i_issue_long, i_retire, i_flush;
  logic [REG_W-1:0]                 i_issue_rd, i_retire_rd;
  logic [NUM_RS-1:0][XLEN-1:0]      o_rs;
  logic                             o_stall, o_error;
  logic [NUM_REGS-1:0]              o_busy;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  cpu_forward_scoreboard #(
    .NUM_RS(NUM_RS), .NUM_STAGES(NUM_STAGES), .XLEN(XLEN),
    .REG_W(REG_W), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_rs_valid(i_rs_valid), .i_rs_idx(i_rs_idx), .i_rs_rf(i_rs_rf),
    .i_stage_valid(i_stage_valid), .i_stage_rd_idx(i_stage_rd_idx),
    .i_stage_rd_data(i_stage_rd_data), .i_stage_rd_ready(i_stage_rd_ready),
    .i_issue(i_issue), .i_issue_long(i_issue_long), .i_issue_rd(i_issue_rd),
    .i_retire(i_retire), .i_retire_rd(i_retire_rd), .i_flush(i_flush),
    .o_rs(o_rs), .o_stall(o_stall), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk_i = ~clk_i;

  task automatic expect_v(input int kind, input int idx, input logic [63:0] val);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Pops every queued expectation and compares it with the live outputs.
  task automatic check(input string tag);
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RS:    obs = 64'(o_rs[e.idx]);
        K_STALL: obs = 64'(o_stall);
        K_BUSY:  obs = 64'(o_busy);
        default: obs = 64'(o_error);
      endcase
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s kind=%0d idx=%0d observed=%h expected=%h", tag, e.kind, e.idx, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    i_rs_valid = '0; i_rs_idx = '0; i_rs_rf = '0;
    i_stage_valid = '0; i_stage_rd_idx = '0; i_stage_rd_data = '0; i_stage_rd_ready = '0;
    i_issue = 0; i_issue_long = 0; i_issue_rd = '0;
    i_retire = 0; i_retire_rd = '0; i_flush = 0;
  endtask

  task automatic set_rs(input int n, input logic [REG_W-1:0] idx, input logic [XLEN-1:0] rf);
    i_rs_valid[n] = 1'b1;
    i_rs_idx[n]   = idx;
    i_rs_rf[n]    = rf;
  endtask

  task automatic set_stage(input int s, input logic [REG_W-1:0] idx,
                           input logic [XLEN-1:0] data, input logic rdy);
    i_stage_valid[s]    = 1'b1;
    i_stage_rd_idx[s]   = idx;
    i_stage_rd_data[s]  = data;
    i_stage_rd_ready[s] = rdy;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    #2;
    expect_v(K_BUSY, 0, 64'h0); expect_v(K_ERR, 0, 64'h0);
    expect_v(K_STALL, 0, 64'h0); expect_v(K_RS, 0, 64'h0);
    check("reset_state");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Youngest stage wins over an older match; non-matching operand reads the RF.
    set_rs(0, 5'd5, 32'h99);
    set_rs(1, 5'd6, 32'h66);
    set_stage(0, 5'd5, 32'h11, 1'b1);
    set_stage(2, 5'd5, 32'h22, 1'b1);
    expect_v(K_RS, 0, 64'h11); expect_v(K_RS, 1, 64'h66);
    expect_v(K_RS, 2, 64'h0);  expect_v(K_STALL, 0, 64'h0);
    check("youngest_priority");

    // Unready forward stalls, then forwards once ready.
    tick(); clear_inputs();
    set_rs(1, 5'd7, 32'h77);
    set_stage(1, 5'd7, 32'hAB, 1'b0);
    expect_v(K_STALL, 0, 64'h1);
    check("fwd_not_ready");
    tick();
    i_stage_rd_ready[1] = 1'b1;
    expect_v(K_RS, 1, 64'hAB); expect_v(K_STALL, 0, 64'h0);
    check("fwd_ready");
    set_stage(0, 5'd7, 32'hCD, 1'b0);
    expect_v(K_STALL, 0, 64'h1);
    check("young_unready_blocks");

    // Long write to r9: pending stalls decode, retire forwards without a bubble.
    tick(); clear_inputs();
    i_issue = 1; i_issue_long = 1; i_issue_rd = 5'd9;
    expect_v(K_STALL, 0, 64'h0); expect_v(K_BUSY, 0, 64'h0);
    check("issue_long_9");
    tick(); clear_inputs();
    set_rs(0, 5'd9, 32'h99);
    expect_v(K_BUSY, 0, 64'h200); expect_v(K_STALL, 0, 64'h1);
    check("pending_stall_9");
    tick();
    i_retire = 1; i_retire_rd = 5'd9;
    set_stage(2, 5'd9, 32'h55, 1'b1);
    expect_v(K_RS, 0, 64'h55); expect_v(K_STALL, 0, 64'h0); expect_v(K_BUSY, 0, 64'h200);
    check("retire_forward_9");
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h0); expect_v(K_ERR, 0, 64'h0);
    check("retired_9");

    // Simultaneous inc/dec on r4 leaves the count at exactly one.
    i_issue = 1; i_issue_long = 1; i_issue_rd = 5'd4;
    tick();
    i_retire = 1; i_retire_rd = 5'd4;
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h10);
    check("inc_dec_same_cycle");
    i_retire = 1; i_retire_rd = 5'd4;
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h0); expect_v(K_ERR, 0, 64'h0);
    check("count_was_one");

    // Flush clears everything and overrides a same-cycle issue and retire.
    i_issue = 1; i_issue_long = 1; i_issue_rd = 5'd10;
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h400);
    check("pending_10");
    i_issue = 1; i_issue_long = 1; i_issue_rd = 5'd11;
    i_retire = 1; i_retire_rd = 5'd13; i_flush = 1;
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h0); expect_v(K_ERR, 0, 64'h0);
    check("flush");

    // Retire with nothing pending is a protocol error.
    i_retire = 1; i_retire_rd = 5'd12;
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h0); expect_v(K_ERR, 0, 64'h1);
    check("underflow_error");

    // Mid-cycle reset drops counts and error without a clock edge.
    i_issue = 1; i_issue_long = 1; i_issue_rd = 5'd20;
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h100000); expect_v(K_ERR, 0, 64'h1);
    check("pre_reset");
    rst_ni = 1'b0;
    expect_v(K_BUSY, 0, 64'h0); expect_v(K_ERR, 0, 64'h0);
    check("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill r3 to MAX_PENDING, then force one more issue through the stall.
    i_issue = 1; i_issue_long = 1; i_issue_rd = 5'd3;
    for (int k = 0; k < MAX_PENDING; k++) begin
      expect_v(K_STALL, 0, 64'h0);
      check("fill_r3");
      tick();
    end
    expect_v(K_STALL, 0, 64'h1); expect_v(K_BUSY, 0, 64'h8); expect_v(K_ERR, 0, 64'h0);
    check("saturated_r3");
    tick();
    i_issue = 0;
    expect_v(K_ERR, 0, 64'h1); expect_v(K_STALL, 0, 64'h1);
    check("forced_issue");
    i_retire = 1; i_retire_rd = 5'd3;
    tick();
    expect_v(K_STALL, 0, 64'h0); expect_v(K_BUSY, 0, 64'h8);
    check("r3_count_2");
    tick();
    expect_v(K_BUSY, 0, 64'h8);
    check("r3_count_1");
    tick(); clear_inputs();
    expect_v(K_BUSY, 0, 64'h0);
    check("r3_count_0");

    // Register zero never forwards or stalls; invalid operand reads zero.
    set_rs(0, 5'd0, 32'h123);
    i_rs_idx[1] = 5'd5; i_rs_rf[1] = 32'h5555;
    set_stage(0, 5'd0, 32'hFF, 1'b1);
    set_stage(1, 5'd5, 32'h77, 1'b0);
    expect_v(K_RS, 0, 64'h0); expect_v(K_RS, 1, 64'h0); expect_v(K_STALL, 0, 64'h0);
    check("reg_zero");
    i_stage_rd_ready[0] = 1'b0;
    expect_v(K_STALL, 0, 64'h0);
    check("reg_zero_unready");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
